// File: rtl/lab3_mem_responder.sv
// Memory-side responder for the 4-byte val/rdy memory protocol with a programmable response latency.
// Define LAB3_MEM_RESPONDER_STATS_EN to add num_reads/num_writes request counters.
package lab3_mem_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module lab3_mem_responder
    import lab3_mem_pkg::*;
#(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  mem_req_4B_t  memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output mem_resp_4B_t memresp_msg
`ifdef LAB3_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]  num_reads,
    output logic [31:0]  num_writes
`endif
);

    localparam int AW = $clog2(NUM_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;

    logic          req_fire;
    logic          resp_fire;
    logic [AW-1:0] req_idx;
    logic [1:0]    req_b;
    logic [2:0]    req_n;
    logic [3:0]    req_end;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          req_is_read;
    logic          req_is_write;

    logic [2:0]    type_reg;
    logic [7:0]    opaque_reg;
    logic [1:0]    len_reg;
    logic [1:0]    b_reg;
    logic [2:0]    n_reg;
    logic          is_read_reg;

    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_masked;

    logic          unused_addr_bits;
    assign unused_addr_bits = &{1'b0, memreq_msg.addr[31:2+AW]};

    // reset gates the handshake outputs combinationally so nothing is offered while it is held
    assign memreq_rdy  = !reset && (state_reg == ST_IDLE);
    assign memresp_val = !reset && (state_reg == ST_RESP);
    assign req_fire    = memreq_val && memreq_rdy;
    assign resp_fire   = memresp_val && memresp_rdy;

    assign req_idx      = memreq_msg.addr[2+AW-1:2];
    assign req_b        = memreq_msg.addr[1:0];
    assign req_n        = (memreq_msg.len == 2'd0) ? 3'd4 : {1'b0, memreq_msg.len};
    assign req_end      = {2'b00, req_b} + {1'b0, req_n};
    assign req_wdata    = memreq_msg.data << {req_b, 3'b000};
    assign req_is_read  = (memreq_msg.type_ == MEM_TYPE_READ);
    assign req_is_write = (memreq_msg.type_ == MEM_TYPE_WRITE) ||
                          (memreq_msg.type_ == MEM_TYPE_INIT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    cnt_next   = 4'(LATENCY);
                    state_next = (LATENCY > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            type_reg    <= 3'd0;
            opaque_reg  <= 8'd0;
            len_reg     <= 2'd0;
            b_reg       <= 2'd0;
            n_reg       <= 3'd0;
            is_read_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (req_fire) begin
                type_reg    <= memreq_msg.type_;
                opaque_reg  <= memreq_msg.opaque;
                len_reg     <= memreq_msg.len;
                b_reg       <= req_b;
                n_reg       <= req_n;
                is_read_reg <= req_is_read;
            end
        end
    end

    // One byte-wide RAM per lane; the read word is captured on the fire edge and
    // stays untouched until the next request, which keeps the response stable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [NUM_WORDS];
        logic [7:0] rd_byte_reg;

        assign req_be[gi] = (4'(gi) >= {2'b00, req_b}) && (4'(gi) < req_end);

        always_ff @(posedge clk) begin
            if (req_fire && req_is_write && req_be[gi]) begin
                mem_lane[req_idx] <= req_wdata[8*gi +: 8];
            end
            if (req_fire && req_is_read) begin
                rd_byte_reg <= mem_lane[req_idx];
            end
        end

        assign rd_word[8*gi +: 8]   = rd_byte_reg;
        assign rd_masked[8*gi +: 8] = (3'(gi) < n_reg) ? rd_shift[8*gi +: 8] : 8'h00;
    end

    assign rd_shift = rd_word >> {b_reg, 3'b000};

    always_comb begin
        memresp_msg = '0;
        if (memresp_val) begin
            memresp_msg.type_  = type_reg;
            memresp_msg.opaque = opaque_reg;
            memresp_msg.test   = 2'd0;
            memresp_msg.len    = len_reg;
            memresp_msg.data   = is_read_reg ? rd_masked : 32'h0;
        end
    end

`ifdef LAB3_MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            num_reads  <= 32'd0;
            num_writes <= 32'd0;
        end else if (req_fire) begin
            if (req_is_read) begin
                num_reads <= num_reads + 32'd1;
            end
            if (req_is_write) begin
                num_writes <= num_writes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lab3_mem_responder.sv
// Scoreboard bench for lab3_mem_responder: three instances with LATENCY 0, 3 and 5.
module tb_lab3_mem_responder;
    import lab3_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_s      [3];
    logic         req_val_s  [3];
    logic         req_rdy_s  [3];
    mem_req_4B_t  req_msg_s  [3];
    logic         resp_val_s [3];
    logic         resp_rdy_s [3];
    mem_resp_4B_t resp_msg_s [3];
`ifdef LAB3_MEM_RESPONDER_STATS_EN
    logic [31:0]  nrd_s [3];
    logic [31:0]  nwr_s [3];
`endif

    function automatic int lat_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        lab3_mem_responder #(
            .NUM_WORDS(256),
            .LATENCY  (lat_of(gi))
        ) u_dut (
            .clk        (clk),
            .reset      (rst_s[gi]),
            .memreq_val (req_val_s[gi]),
            .memreq_rdy (req_rdy_s[gi]),
            .memreq_msg (req_msg_s[gi]),
            .memresp_val(resp_val_s[gi]),
            .memresp_rdy(resp_rdy_s[gi]),
            .memresp_msg(resp_msg_s[gi])
`ifdef LAB3_MEM_RESPONDER_STATS_EN
            ,
            .num_reads  (nrd_s[gi]),
            .num_writes (nwr_s[gi])
`endif
        );
    end

    int           n_checks = 0;
    int           n_err    = 0;
    mem_resp_4B_t sb_q [$];
    logic [31:0]  model_mem [3][256];
    int           exp_rd [3];
    int           exp_wr [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-at-a-time reference of the access semantics.
    task automatic model_apply(input int d, input mem_req_4B_t req, output mem_resp_4B_t exp);
        int          n;
        int          b;
        logic [7:0]  idx;
        logic [31:0] w;
        n   = (req.len == 2'd0) ? 4 : int'(req.len);
        b   = int'(req.addr[1:0]);
        idx = req.addr[9:2];
        w   = model_mem[d][idx];
        exp = '0;
        exp.type_  = req.type_;
        exp.opaque = req.opaque;
        exp.len    = req.len;
        if (req.type_ == MEM_TYPE_READ) begin
            for (int k = 0; k < n; k++)
                if (b + k < 4) exp.data[8*k +: 8] = w[8*(b+k) +: 8];
        end else if (req.type_ == MEM_TYPE_WRITE || req.type_ == MEM_TYPE_INIT) begin
            for (int k = 0; k < n; k++)
                if (b + k < 4) w[8*(b+k) +: 8] = req.data[8*k +: 8];
            model_mem[d][idx] = w;
        end
    endtask

    task automatic do_txn(input int d, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] data,
                          input logic [7:0] opq, input int hold);
        mem_req_4B_t  req;
        mem_resp_4B_t exp;
        mem_resp_4B_t got;
        int           fire_cyc;
        bit           ok;
        req.type_  = typ;
        req.opaque = opq;
        req.addr   = addr;
        req.len    = len;
        req.data   = data;
        model_apply(d, req, exp);
        sb_q.push_back(exp);
        req_msg_s[d] = req;
        req_val_s[d] = 1'b1;
        ok       = 1'b0;
        fire_cyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_rdy_s[d]) begin
                ok       = 1'b1;
                fire_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        req_val_s[d] = 1'b0;
        if (!ok) begin
            check_eq("req_accept", 64'd0, 64'd1);
            void'(sb_q.pop_front());
            return;
        end
        if (typ == MEM_TYPE_READ) exp_rd[d]++;
        if (typ == MEM_TYPE_WRITE || typ == MEM_TYPE_INIT) exp_wr[d]++;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (resp_val_s[d]) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        exp = sb_q.pop_front();
        if (!ok) begin
            check_eq("resp_timeout", 64'd0, 64'd1);
            return;
        end
        check_eq("latency", 64'(cyc - fire_cyc), 64'(1 + lat_of(d)));
        got = resp_msg_s[d];
        check_eq("resp_msg", 64'(got), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_val", 64'(resp_val_s[d]), 64'd1);
            check_eq("hold_msg", 64'(resp_msg_s[d]), 64'(exp));
            check_eq("hold_reqrdy", 64'(req_rdy_s[d]), 64'd0);
        end
        resp_rdy_s[d] = 1'b1;
        @(posedge clk); #1;
        resp_rdy_s[d] = 1'b0;
        check_eq("post_val", 64'(resp_val_s[d]), 64'd0);
        check_eq("post_reqrdy", 64'(req_rdy_s[d]), 64'd1);
        $display("txn dut%0d type=%0d addr=%h len=%0d wdata=%h opq=%h -> resp type=%0d opq=%h data=%h",
                 d, typ, addr, len, data, opq, got.type_, got.opaque, got.data);
    endtask

    task automatic apply_reset(input int d, input int cycles);
        rst_s[d] = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check_eq("rst_reqrdy", 64'(req_rdy_s[d]), 64'd0);
            check_eq("rst_respval", 64'(resp_val_s[d]), 64'd0);
            check_eq("rst_respmsg", 64'(resp_msg_s[d]), 64'd0);
        end
        rst_s[d] = 1'b0;
        exp_rd[d] = 0;
        exp_wr[d] = 0;
        #1;
        check_eq("post_rst_reqrdy", 64'(req_rdy_s[d]), 64'd1);
        $display("reset dut%0d for %0d cycles", d, cycles);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        mem_req_4B_t req;
        bit          seen;
        logic [31:0] a;
        for (int d = 0; d < 3; d++) begin
            rst_s[d]      = 1'b1;
            req_val_s[d]  = 1'b0;
            req_msg_s[d]  = '0;
            resp_rdy_s[d] = 1'b0;
            exp_rd[d]     = 0;
            exp_wr[d]     = 0;
            for (int w = 0; w < 256; w++) model_mem[d][w] = 32'h0;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) apply_reset(d, 2);

        // LATENCY=0 basic write/read
        do_txn(0, MEM_TYPE_WRITE, 32'h10, 2'd0, 32'hDEADBEEF, 8'h05, 0);
        do_txn(0, MEM_TYPE_READ,  32'h10, 2'd0, 32'h0, 8'h06, 0);

        // subword accesses
        do_txn(0, MEM_TYPE_INIT,  32'h20, 2'd0, 32'h11223344, 8'h10, 0);
        do_txn(0, MEM_TYPE_WRITE, 32'h21, 2'd1, 32'h000000AB, 8'h11, 0);
        do_txn(0, MEM_TYPE_READ,  32'h20, 2'd0, 32'h0, 8'h12, 0);
        do_txn(0, MEM_TYPE_READ,  32'h22, 2'd2, 32'h0, 8'h13, 0);
        do_txn(0, MEM_TYPE_READ,  32'h23, 2'd3, 32'h0, 8'h14, 0);
        do_txn(0, MEM_TYPE_WRITE, 32'h23, 2'd2, 32'h0000CDEF, 8'h15, 0);
        do_txn(0, MEM_TYPE_READ,  32'h21, 2'd3, 32'h0, 8'h16, 0);

        // aliasing and unknown type
        do_txn(0, MEM_TYPE_WRITE, 32'h400, 2'd0, 32'h00000005, 8'h20, 0);
        do_txn(0, MEM_TYPE_READ,  32'h0,   2'd0, 32'h0, 8'h21, 0);
        do_txn(0, 3'd5,           32'h0,   2'd0, 32'hFFFFFFFF, 8'h22, 0);
        do_txn(0, MEM_TYPE_READ,  32'h800, 2'd0, 32'h0, 8'h23, 0);

        // randomized subword traffic over a pre-initialised window
        for (int w = 0; w < 16; w++)
            do_txn(0, MEM_TYPE_WRITE, 32'h100 + 32'(4*w), 2'd0, $urandom, 8'(w), 0);
        for (int i = 0; i < 24; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            do_txn(0, ($urandom_range(0, 1) == 0) ? MEM_TYPE_READ : MEM_TYPE_WRITE,
                   a, 2'($urandom_range(0, 3)), $urandom, 8'($urandom), 0);
        end

        // LATENCY=3 with backpressure
        do_txn(1, MEM_TYPE_WRITE, 32'h8, 2'd0, 32'h12345678, 8'h31, 0);
        do_txn(1, MEM_TYPE_READ,  32'h8, 2'd0, 32'h0, 8'h32, 5);
        do_txn(1, MEM_TYPE_INIT,  32'hC, 2'd0, 32'hA5A5A5A5, 8'h33, 2);
        do_txn(1, MEM_TYPE_READ,  32'hD, 2'd2, 32'h0, 8'h34, 0);

        // LATENCY=5: reset while the response is pending
        do_txn(2, MEM_TYPE_WRITE, 32'h40, 2'd0, 32'hCAFEF00D, 8'h41, 0);
        req.type_  = MEM_TYPE_READ;
        req.opaque = 8'h42;
        req.addr   = 32'h40;
        req.len    = 2'd0;
        req.data   = 32'h0;
        req_msg_s[2] = req;
        req_val_s[2] = 1'b1;
        check_eq("abort_reqrdy", 64'(req_rdy_s[2]), 64'd1);
        @(posedge clk); #1;
        req_val_s[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_wait_val", 64'(resp_val_s[2]), 64'd0);
        check_eq("abort_wait_reqrdy", 64'(req_rdy_s[2]), 64'd0);
        apply_reset(2, 2);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resp_val_s[2]) seen = 1'b1;
        end
        check_eq("abort_no_resp", 64'(seen), 64'd0);
        do_txn(2, MEM_TYPE_READ,  32'h40, 2'd0, 32'h0, 8'h43, 0);
        do_txn(2, MEM_TYPE_WRITE, 32'h44, 2'd0, 32'h01020304, 8'h44, 0);
        do_txn(2, MEM_TYPE_READ,  32'h44, 2'd1, 32'h0, 8'h45, 0);
        do_txn(2, MEM_TYPE_WRITE, 32'h46, 2'd2, 32'h0000BEEF, 8'h46, 0);
        do_txn(2, MEM_TYPE_READ,  32'h44, 2'd0, 32'h0, 8'h47, 0);

`ifdef LAB3_MEM_RESPONDER_STATS_EN
        check_eq("num_reads",  64'(nrd_s[2]), 64'd3);
        check_eq("num_writes", 64'(nwr_s[2]), 64'd2);
        check_eq("num_reads0",  64'(nrd_s[0]), 64'(exp_rd[0]));
        check_eq("num_writes0", 64'(nwr_s[0]), 64'(exp_wr[0]));
        apply_reset(2, 1);
        check_eq("num_reads_rst",  64'(nrd_s[2]), 64'd0);
        check_eq("num_writes_rst", 64'(nwr_s[2]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
